// File: rtl/shared_sram_arbiter.sv
// shared_sram_arbiter: owns the shared 64x8 SRAM macro used by the QCPU and
// MC14500 cores and adds a Wishbone slave window for the management SoC.
// The selected core always has priority. A Wishbone access waits while that
// core writes, then takes exactly one macro slot.
// Optional feature macro: SRAM_WB_LOCK_EN. When it is defined, Wishbone writes
// into the SRAM window are dropped while the selected core is running, and the
// lock error flag is set.
module shared_sram_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0400,
  parameter logic [7:0]  STAT_OFS  = 8'h00
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        core_sel,
  input  logic        core_rst_n,
  input  logic [5:0]  qcpu_sram_addr,
  input  logic [7:0]  qcpu_sram_in,
  input  logic        qcpu_sram_gwe,
  input  logic [5:0]  mc_sram_addr,
  input  logic [7:0]  mc_sram_in,
  input  logic        mc_sram_gwe,
  output logic [7:0]  core_sram_out,
  output logic [5:0]  sram_addr,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout,
  output logic        sram_cen_n,
  output logic        sram_gwen_n
);

  localparam logic [31:0] STAT_ADDR = ADDR_BASE + 32'h0000_0100 + {24'h0, STAT_OFS};

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

  state_e      state_q, state_d;
  logic [7:0]  stall_q, stall_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        lock_q, lock_d;
  logic        stat_q, stat_d;
  logic        wr_q, wr_d;
  logic        hold_q, hold_d;
  logic [7:0]  last_q, last_d;
  logic        active_q;

  logic        wb_issue;
  logic        wb_req;
  logic        win_hit;
  logic        stat_hit;
  logic        lock_blk;
  logic [31:0] win_ofs;
  logic [5:0]  core_addr;
  logic [7:0]  core_din;
  logic        core_gwe;
  logic [31:0] status;
  logic        unused_ok;

  assign unused_ok = &{1'b0, wbs_dat_i[31:8], core_rst_n};

  // Select the active core's SRAM nets; the other port is ignored completely
  always_comb begin
    core_addr = core_sel ? mc_sram_addr : qcpu_sram_addr;
    core_din  = core_sel ? mc_sram_in   : qcpu_sram_in;
    core_gwe  = core_sel ? mc_sram_gwe  : qcpu_sram_gwe;
  end

  // Decode the Wishbone address into SRAM-window and status-register hits
  always_comb begin
    wb_req   = wbs_cyc_i && wbs_stb_i;
    win_ofs  = wbs_adr_i - ADDR_BASE;
    win_hit  = wb_req && (win_ofs < 32'h0000_0100);
    stat_hit = wb_req && (wbs_adr_i[31:2] == STAT_ADDR[31:2]);
`ifdef SRAM_WB_LOCK_EN
    lock_blk = wbs_we_i && core_rst_n;
`else
    lock_blk = 1'b0;
`endif
    status   = {14'h0, lock_q, core_sel, wcnt_q, stall_q};
  end

  // Next-state logic for the Wishbone access FSM and its counters
  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    wcnt_d   = wcnt_q;
    lock_d   = lock_q;
    stat_d   = stat_q;
    wr_d     = wr_q;
    wb_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (stat_hit) begin
          state_d = DATA;
          stat_d  = 1'b1;
          wr_d    = wbs_we_i;
          if (wbs_we_i) begin
            stall_d = 8'h00;
            lock_d  = 1'b0;
          end
        end else if (win_hit) begin
          stat_d = 1'b0;
          wr_d   = wbs_we_i;
          if (lock_blk) begin
            lock_d  = 1'b1;
            state_d = DATA;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (!wb_req) begin
          state_d = IDLE;
        end else if (core_gwe) begin
          stall_d = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
        end else begin
          wb_issue = 1'b1;
          if (wbs_we_i) begin
            wcnt_d = wcnt_q + 8'd1;
          end
          state_d = DATA;
        end
      end
      DATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive the macro from the selected core unless Wishbone owns this slot
  always_comb begin
    sram_addr   = 6'd0;
    sram_din    = 8'd0;
    sram_cen_n  = 1'b1;
    sram_gwen_n = 1'b1;
    if (active_q) begin
      sram_cen_n = 1'b0;
      if (wb_issue) begin
        sram_addr   = wbs_adr_i[7:2];
        sram_din    = wbs_dat_i[7:0];
        sram_gwen_n = ~wbs_we_i;
      end else begin
        sram_addr   = core_addr;
        sram_din    = core_din;
        sram_gwen_n = ~core_gwe;
      end
    end
  end

  // Wishbone response and core read data, holding the core value over a stolen slot
  always_comb begin
    wbs_ack_o = (state_q == DATA);
    wbs_dat_o = 32'h0;
    if (wbs_ack_o && !wr_q) begin
      wbs_dat_o = stat_q ? status : {24'h0, sram_dout};
    end
    if (!active_q) begin
      core_sram_out = 8'h00;
    end else if (hold_q) begin
      core_sram_out = last_q;
    end else begin
      core_sram_out = sram_dout;
    end
    hold_d = wb_issue;
    last_d = core_sram_out;
  end

  // State and counter registers, cleared asynchronously by rst_n
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stall_q  <= 8'h00;
      wcnt_q   <= 8'h00;
      lock_q   <= 1'b0;
      stat_q   <= 1'b0;
      wr_q     <= 1'b0;
      hold_q   <= 1'b0;
      last_q   <= 8'h00;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      wcnt_q   <= wcnt_d;
      lock_q   <= lock_d;
      stat_q   <= stat_d;
      wr_q     <= wr_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      active_q <= 1'b1;
    end
  end

endmodule
